// File: rtl/irq_arbiter_pkg.sv
// irq_arbiter_pkg: shared definitions for the interrupt arbiter.
//   - arb_state_e        : arbiter FSM state encoding
//   - DEFAULT_VEC_STRIDE : default byte distance between source vectors
//   - SRC_*              : board-level source index assignments
package irq_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAssert = 2'd1,
        StHold   = 2'd2
    } arb_state_e;

    localparam int unsigned DEFAULT_VEC_STRIDE = 4;

    localparam int unsigned SRC_KBD   = 0;
    localparam int unsigned SRC_BP    = 1;
    localparam int unsigned SRC_IR    = 2;
    localparam int unsigned SRC_SPARE = 3;

endpackage

// File: rtl/irq_edge_capture.sv
// irq_edge_capture: per-source rising-edge detector with sticky pending/overflow
// flags and a payload register.
//   clk, rst    : clock, asynchronous active-high reset
//   req_i       : request level; a rising edge is one event
//   data_i      : payload sampled on the event edge
//   clr_i       : arbiter strobe clearing pending on dispatch
//   pending_o   : sticky pending flag
//   overflow_o  : sticky lost-event flag (reset only)
//   data_o      : latest captured payload
module irq_edge_capture #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              clr_i,
    output logic              pending_o,
    output logic              overflow_o,
    output logic [DATA_W-1:0] data_o
);

    logic              prev_q;
    logic              pending_q, pending_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              evt;

    always_comb begin
        evt        = req_i & ~prev_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        data_d     = data_q;
        if (clr_i) begin
            pending_d = 1'b0;
        end
        // An event beats a same-cycle clear; it only counts as lost when the
        // old event is not being dispatched right now.
        if (evt) begin
            pending_d = 1'b1;
            data_d    = data_i;
            if (pending_q && !clr_i) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q     <= 1'b0;
            pending_q  <= 1'b0;
            overflow_q <= 1'b0;
            data_q     <= '0;
        end else begin
            prev_q     <= req_i;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            data_q     <= data_d;
        end
    end

    assign pending_o  = pending_q;
    assign overflow_o = overflow_q;
    assign data_o     = data_q;

endmodule

// File: rtl/irq_arbiter.sv
// irq_arbiter: collects edge-triggered interrupt events from NUM_SRC sources and
// dispatches them one at a time (lowest index first) to the CPU interrupt port.
//   clk, rst    : clock, asynchronous active-high reset
//   src_req_i   : per-source request levels
//   src_data_i  : per-source payloads, slice i belongs to source i
//   src_en_i    : per-source enable mask
//   int_en_i    : global interrupt enable
//   vec_base_i  : vector table base address
//   ack_i       : CPU acknowledge (level)
//   irq_o       : interrupt request
//   int_data_o  : payload of the dispatched source
//   int_addr_o  : vector address of the dispatched source
//   src_id_o    : index of the dispatched source
//   pending_o   : sticky pending bits
//   overflow_o  : sticky lost-event flags
module irq_arbiter
    import irq_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned VEC_STRIDE = DEFAULT_VEC_STRIDE,
    parameter int unsigned HOLDOFF    = 3,
    localparam int unsigned IdW       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_req_i,
    input  logic [NUM_SRC*DATA_W-1:0] src_data_i,
    input  logic [NUM_SRC-1:0]        src_en_i,
    input  logic                      int_en_i,
    input  logic [ADDR_W-1:0]         vec_base_i,
    input  logic                      ack_i,
    output logic                      irq_o,
    output logic [DATA_W-1:0]         int_data_o,
    output logic [ADDR_W-1:0]         int_addr_o,
    output logic [IdW-1:0]            src_id_o,
    output logic [NUM_SRC-1:0]        pending_o,
    output logic [NUM_SRC-1:0]        overflow_o
);

    localparam int unsigned CntW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    logic [NUM_SRC-1:0]             pend_s, ovf_s, clr_s, elig_s;
    logic [NUM_SRC-1:0][DATA_W-1:0] cap_data;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        irq_edge_capture #(
            .DATA_W (DATA_W)
        ) u_cap (
            .clk        (clk),
            .rst        (rst),
            .req_i      (src_req_i[g]),
            .data_i     (src_data_i[g*DATA_W +: DATA_W]),
            .clr_i      (clr_s[g]),
            .pending_o  (pend_s[g]),
            .overflow_o (ovf_s[g]),
            .data_o     (cap_data[g])
        );
    end

    arb_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [IdW-1:0]    id_q, id_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pick_valid;
    logic [IdW-1:0]    pick_idx;

    // Fixed priority: scan downward so the lowest eligible index ends up chosen.
    always_comb begin
        elig_s     = pend_s & src_en_i & {NUM_SRC{int_en_i}};
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig_s[i]) begin
                pick_valid = 1'b1;
                pick_idx   = IdW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        data_d  = data_q;
        addr_d  = addr_q;
        clr_s   = '0;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d         = StAssert;
                    id_d            = pick_idx;
                    data_d          = cap_data[pick_idx];
                    addr_d          = vec_base_i + ADDR_W'(pick_idx) * ADDR_W'(VEC_STRIDE);
                    clr_s[pick_idx] = 1'b1;
                end
            end
            StAssert: begin
                if (ack_i) begin
                    state_d = StHold;
                    cnt_d   = CntW'(HOLDOFF);
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            id_q    <= '0;
            data_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
        end
    end

    assign irq_o      = (state_q == StAssert);
    assign int_data_o = data_q;
    assign int_addr_o = addr_q;
    assign src_id_o   = id_q;
    assign pending_o  = pend_s;
    assign overflow_o = ovf_s;

endmodule
